// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between two clients; push acks in 3 cycles, pop in 4.
// Requests are sampled only in IDLE, so a client waits by holding req high until its ack.
module lifo_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  op0,
  input  logic                  op1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  stk_write_en,
  output logic                  stk_read_en,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_empty,
  input  logic                  stk_full
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t                state;
  logic                  win_q;
  logic                  op_q;
  logic                  err_q;
  logic                  last_grant;

  logic                  grant;
  logic                  grant_op;
  logic [DATA_WIDTH-1:0] grant_wdata;

  // On a tie the client that did not win last time takes the grant.
  assign grant       = (req0 && req1) ? ~last_grant : req1;
  assign grant_op    = grant ? op1 : op0;
  assign grant_wdata = grant ? wdata1 : wdata0;

  // The stack only changes on our own strobes, so its flags are stable from the
  // grant edge through ISSUE; deciding at the grant lets the strobes be registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      win_q        <= 1'b0;
      op_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant   <= 1'b1;
      rdata0       <= '0;
      rdata1       <= '0;
      stk_write_en <= 1'b0;
      stk_read_en  <= 1'b0;
      stk_data_in  <= '0;
    end else begin
      stk_write_en <= 1'b0;
      stk_read_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win_q       <= grant;
            last_grant  <= grant;
            op_q        <= grant_op;
            stk_data_in <= grant_wdata;
            if (grant_op) begin
              stk_read_en <= !stk_empty;
              err_q       <= stk_empty;
            end else begin
              stk_write_en <= !stk_full;
              err_q        <= stk_full;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= (op_q && !err_q) ? CAPTURE : ACK;
        end
        CAPTURE: begin
          if (win_q) rdata1 <= stk_data_out;
          else       rdata0 <= stk_data_out;
          state <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign ack0 = (state == ACK) && !win_q;
  assign ack1 = (state == ACK) &&  win_q;
  assign err0 = ack0 && err_q;
  assign err1 = ack1 && err_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a behavioural 16-deep stack attached.
module tb_lifo_arbiter;

  logic       clock;
  logic       resetn;
  logic       req0, req1, op0, op1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic       busy;
  logic       stk_write_en, stk_read_en;
  logic [7:0] stk_data_in, stk_data_out;
  logic       stk_empty, stk_full;

  int compared = 0;
  int failed   = 0;
  int wr_cnt = 0, rd_cnt = 0, both_stb = 0, both_ack = 0, ack_cnt = 0;

  lifo_arbiter #(.DATA_WIDTH(8)) dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .stk_write_en(stk_write_en), .stk_read_en(stk_read_en),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_empty(stk_empty), .stk_full(stk_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stack model: data_out and pointer registered on the strobe edge.
  logic [7:0] mem [16];
  int sp;
  always @(posedge clock) begin
    if (!resetn) begin
      sp           <= 0;
      stk_data_out <= 8'h00;
    end else if (stk_write_en && sp < 16) begin
      mem[sp] <= stk_data_in;
      sp      <= sp + 1;
    end else if (stk_read_en && sp > 0) begin
      stk_data_out <= mem[sp-1];
      sp           <= sp - 1;
    end
  end
  assign stk_full  = (sp == 16);
  assign stk_empty = (sp == 0);

  always @(negedge clock) begin
    if (stk_write_en) wr_cnt++;
    if (stk_read_en) rd_cnt++;
    if (stk_write_en && stk_read_en) both_stb++;
    if (ack0 && ack1) both_ack++;
    if (ack0 || ack1) ack_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request/ack handshake; expected values supplied by the caller.
  task automatic do_op(input bit c, input bit op, input logic [7:0] wd,
                       input bit exp_err, input logic [7:0] exp_rd, input string tag);
    int n;
    int exp_lat;
    exp_lat = (op && !exp_err) ? 3 : 2;
    if (c) begin req1 = 1'b1; op1 = op; wdata1 = wd; end
    else   begin req0 = 1'b1; op0 = op; wdata0 = wd; end
    tick;
    n = 1;
    while (!(ack0 || ack1) && n < 8) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_ack"}, c ? ack1 : ack0, 1);
    chk({tag, "_oth"}, c ? ack0 : ack1, 0);
    chk({tag, "_err"}, c ? err1 : err0, exp_err);
    if (op) chk({tag, "_rd"}, c ? rdata1 : rdata0, exp_rd);
    if (c) req1 = 1'b0; else req0 = 1'b0;
    tick;
    chk({tag, "_idle"}, {busy, ack0, ack1}, 3'b000);
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
  endtask

  initial begin
    int w0, r0, a0;
    logic [7:0] rd_hold;
    resetn = 1'b0;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; wdata0 = 0; wdata1 = 0;
    tick;
    tick;
    chk("rst_ctl", {ack0, ack1, err0, err1, busy, stk_write_en, stk_read_en}, 7'b0);
    chk("rst_rd0", rdata0, 8'h00);
    chk("rst_rd1", rdata1, 8'h00);
    chk("rst_din", stk_data_in, 8'h00);
    resetn = 1'b1;
    tick;

    // Client 0 push 0xA5 step by step; wdata change after grant must be ignored.
    req0 = 1; op0 = 0; wdata0 = 8'hA5;
    tick;
    chk("p0_wen", stk_write_en, 1);
    chk("p0_ren", stk_read_en, 0);
    chk("p0_din", stk_data_in, 8'hA5);
    chk("p0_busy", busy, 1);
    wdata0 = 8'hFF; op0 = 1;
    tick;
    chk("p0_ack", {ack0, err0, ack1}, 3'b100);
    req0 = 0;
    tick;
    chk("p0_idle", {busy, ack0}, 2'b00);

    // Client 1 push/push/pop/pop.
    do_op(1, 0, 8'h11, 0, 8'h00, "c1_push11");
    do_op(1, 0, 8'h22, 0, 8'h00, "c1_push22");
    do_op(1, 1, 8'h00, 0, 8'h22, "c1_pop22");
    do_op(1, 1, 8'h00, 0, 8'h11, "c1_pop11");

    // Drain 0xA5 to client 0, then pop on empty.
    do_op(0, 1, 8'h00, 0, 8'hA5, "c0_popA5");
    r0 = rd_cnt;
    do_op(0, 1, 8'h00, 1, 8'hA5, "c0_popempty");
    chk("empty_noren", rd_cnt, r0);

    // Both clients request continuously after reset: grants 0,1,0,1.
    do_reset;
    req0 = 1; op0 = 0; wdata0 = 8'h30;
    req1 = 1; op1 = 0; wdata1 = 8'h31;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      while (!(ack0 || ack1) && n < 8) begin
        tick;
        n++;
      end
      chk($sformatf("rr%0d_who", k), {ack1, ack0}, (k % 2) ? 2'b10 : 2'b01);
      tick;
    end
    req0 = 0; req1 = 0;
    tick;
    tick;
    chk("rr_bothack", both_ack, 0);
    do_op(1, 1, 8'h00, 0, 8'h31, "rr_pop31");

    // Fill to 16, reject 17th, pop returns 16th word.
    do_reset;
    for (int i = 0; i < 16; i++)
      do_op(0, 0, 8'h40 + 8'(i), 0, 8'h00, $sformatf("fill%0d", i));
    w0 = wr_cnt;
    do_op(0, 0, 8'hEE, 1, 8'h00, "push_full");
    chk("full_nowen", wr_cnt, w0);
    do_op(1, 1, 8'h00, 0, 8'h4F, "pop_16th");

    // Reset during the ISSUE cycle of a pop.
    rd_hold = rdata1;
    a0 = ack_cnt;
    req1 = 1; op1 = 1;
    tick;
    chk("mid_ren", stk_read_en, 1);
    resetn = 0;
    tick;
    req1 = 0;
    chk("mid_ctl", {ack0, ack1, err0, err1, busy, stk_write_en, stk_read_en}, 7'b0);
    chk("mid_rd", {rdata0, rdata1, stk_data_in}, 24'h0);
    resetn = 1;
    tick;
    tick;
    chk("mid_noack", ack_cnt, a0);
    chk("mid_rdheld", rd_hold, 8'h4F);
    do_op(1, 0, 8'h77, 0, 8'h00, "post_push");
    do_op(1, 1, 8'h00, 0, 8'h77, "post_pop");
    do_op(0, 1, 8'h00, 1, 8'h00, "post_empty");

    chk("one_strobe", both_stb, 0);
    chk("one_ack", both_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/lifo_arbiter.md
# lifo_arbiter

Two-requester controller that shares one 16-deep, 8-bit LIFO stack between two clients. It arbitrates push/pop requests round-robin, sequences the stack's write/read strobes, and captures popped data. It returns a one-cycle acknowledge with data or an error flag to the granted client. It sits between client logic and the stack instance; the stack shares the same clock and resetn.

## Interface
Parameters:
- DATA_WIDTH, 8, word width of client and stack data.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- req0 / req1  in  1  request from client 0 / client 1, level.
- op0 / op1  in  1  operation: 0 = push, 1 = pop.
- wdata0 / wdata1  in  DATA_WIDTH  push data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with ack: push rejected (full) or pop rejected (empty).
- rdata0 / rdata1  out  DATA_WIDTH  popped word, valid with ack on a successful pop.
- busy  out  1  high in every state except IDLE.
- stk_write_en  out  1  stack push strobe.
- stk_read_en  out  1  stack pop strobe.
- stk_data_in  out  DATA_WIDTH  stack push data.
- stk_data_out  in  DATA_WIDTH  stack read data, registered by the stack on the read_en edge.
- stk_empty / stk_full  in  1  stack flags.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE: requests are sampled only here.
  - If either req is high, register the winner index, op and wdata, update last_grant, then go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single requester wins outright.
  - If both requesters are high, the one not equal to last_grant wins.
  - last_grant resets to 1, so client 0 wins the first tie.
- ISSUE, push:
  - If !stk_full: stk_write_en = 1 and stk_data_in = latched wdata for this cycle, then go to ACK with err = 0.
  - If stk_full: no strobe, go to ACK with err = 1.
- ISSUE, pop:
  - If !stk_empty: stk_read_en = 1, then go to CAPTURE.
  - If stk_empty: no strobe, go to ACK with err = 1 and rdata unchanged.
- CAPTURE: register stk_data_out into the winner's rdata, then go to ACK.
- ACK:
  - The winner's ack is high for exactly one cycle, and its err reflects the outcome.
  - The other client's ack/err stay 0.
  - Go to IDLE.
- At most one stack strobe is high in any cycle. Strobes are high only in ISSUE.
- Stack flags are sampled in ISSUE only. The controller keeps no occupancy count of its own.
- Latched op/wdata are used, so client input changes after grant have no effect.
- A req still high in the IDLE cycle after ack is a new request. Clients drop req on the edge that ends their ack cycle.
- rdataN holds its last value until the next successful pop for client N.

## Timing
- Reset (resetn low at an edge):
  - state = IDLE, last_grant = 1.
  - ack0/1, err0/1, busy, stk_write_en, stk_read_en = 0.
  - rdata0/1 and stk_data_in = 0.
- Reset mid-operation abandons the op with no ack. If the stack strobe was high in that cycle, the stack is reset by the same edge.
- Cycle counts, with req high in IDLE cycle T:
  - Push, or any rejected op: ISSUE at T+1, ack at T+2. Throughput is one op per 3 cycles.
  - Successful pop: ISSUE at T+1, CAPTURE at T+2, ack with data at T+3. Throughput is one op per 4 cycles.
- busy is high in cycles T+1 through the ack cycle.
- Outputs are Moore-decoded from registered state and registered data, with no combinational input-to-output paths.
- Stack boundaries: a push with the stack holding 16 entries returns err. A pop with 0 entries returns err. Neither event changes the stack.

## Test plan
- Reset, then client 0 pushes 0xA5 -> stk_write_en high with stk_data_in = 0xA5 at T+1; ack0 = 1, err0 = 0 at T+2; busy low at T+3.
- Client 1 pushes 0x11 then 0x22, then pops twice -> rdata1 = 0x22 (ack at T+3), then 0x11; err1 = 0 throughout.
- Both clients request continuously after reset -> grants alternate 0, 1, 0, 1; no ack0 and ack1 ever in the same cycle.
- Pop on empty from client 0 -> ack0 = 1 and err0 = 1 at T+2; stk_read_en never high; rdata0 unchanged.
- 16 pushes, then a 17th push -> 17th returns err = 1 with no stk_write_en; a following pop returns the 16th word.
- resetn low in the ISSUE cycle of a pop -> no ack, all outputs 0 after the edge, state IDLE; a following request completes normally.
